prefix_sub_pipe: RTL

- Pipelined WIDTH-bit subtractor computing A − B as A + ~B + 1.
- Carries come from a Kogge-Stone parallel-prefix tree built from the existing group generate/propagate combine cell: G = Gi | (Pi & Gprev), P = Pi & Pprev.
- Four register stages with a valid/ready handshake on each side and a per-operation tag.
- Sits beside the 64-bit adders as the subtract/compare path.

---
 rtl/prefix_sub_pipe_if.sv | 11 +
 rtl/prefix_sub_pipe.sv | 99 +++++++++
 2 files changed

// File: rtl/prefix_sub_pipe_if.sv
// prefix_sub_pipe_if: operand/result valid-ready bundle for prefix_sub_pipe.
interface prefix_sub_pipe_if #(parameter int WIDTH = 64, parameter int TAGW = 4);
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_a, in_b, out_diff;
    logic             out_borrow, out_ovf, out_zero;
    logic [TAGW-1:0]  in_tag, out_tag;
    modport master (output in_valid, in_a, in_b, in_tag, out_ready,
                    input in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero, out_tag);
    modport slave  (input in_valid, in_a, in_b, in_tag, out_ready,
                    output in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero, out_tag);
endinterface

// File: rtl/prefix_sub_pipe.sv
// prefix_sub_pipe: 4-stage A-B (A + ~B + 1) with a Kogge-Stone carry tree split over two stages.
module prefix_sub_pipe #(parameter int WIDTH = 64, parameter int TAGW = 4) (
    input logic           clk,
    input logic           rst_n,
    prefix_sub_pipe_if.slave bus
);
    localparam int L   = $clog2(WIDTH);
    localparam int LS2 = L / 2;
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] g, p, h;
        logic             am, bm;
        logic [TAGW-1:0]  tag;
    } gp_t;
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] g, h;
        logic             am, bm;
        logic [TAGW-1:0]  tag;
    } car_t;
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] diff;
        logic             borrow, ovf, zero;
        logic [TAGW-1:0]  tag;
    } res_t;
    gp_t  s1_q, s1_d, s2_q, s2_d;
    car_t s3_q, s3_d;
    res_t s4_q, s4_d;
    logic             adv;
    logic [WIDTH-1:0] bn;
    // Vectorised combine cell; positions below the span see a zero neighbour,
    // which is exact because every group reaching bit 0 has P = 0 (p0 = 0).
    function automatic logic [WIDTH-1:0] prefix(input logic [WIDTH-1:0] g_in, p_in,
                                                 input int lo, input int hi, input logic sel_p);
        logic [WIDTH-1:0] g, p;
        g = g_in;
        p = p_in;
        for (int k = lo; k <= hi; k++) begin
            g = g | (p & (g << (1 << (k - 1))));
            p = p & (p << (1 << (k - 1)));
        end
        return sel_p ? p : g;
    endfunction
    always_comb begin
        adv  = !s4_q.v | bus.out_ready;
        bn   = ~bus.in_b;
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        s4_d = s4_q;
        if (adv) begin
            s1_d.v    = bus.in_valid;
            s1_d.g    = bus.in_a & bn;
            s1_d.g[0] = bus.in_a[0] | bn[0];
            s1_d.p    = bus.in_a ^ bn;
            s1_d.p[0] = 1'b0;
            s1_d.h    = bus.in_a ^ bn;
            s1_d.am   = bus.in_a[WIDTH-1];
            s1_d.bm   = bn[WIDTH-1];
            s1_d.tag  = bus.in_tag;
            s2_d      = s1_q;
            s2_d.g    = prefix(s1_q.g, s1_q.p, 1, LS2, 1'b0);
            s2_d.p    = prefix(s1_q.g, s1_q.p, 1, LS2, 1'b1);
            s3_d.v    = s2_q.v;
            s3_d.g    = prefix(s2_q.g, s2_q.p, LS2 + 1, L, 1'b0);
            s3_d.h    = s2_q.h;
            s3_d.am   = s2_q.am;
            s3_d.bm   = s2_q.bm;
            s3_d.tag  = s2_q.tag;
            s4_d.v      = s3_q.v;
            s4_d.diff   = s3_q.h ^ {s3_q.g[WIDTH-2:0], 1'b1};
            s4_d.borrow = ~s3_q.g[WIDTH-1];
            s4_d.ovf    = (s3_q.am == s3_q.bm) & (s4_d.diff[WIDTH-1] != s3_q.am);
            s4_d.zero   = ~|s4_d.diff;
            s4_d.tag    = s3_q.tag;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            s4_q <= s4_d;
        end
    end
    assign bus.in_ready   = adv;
    assign bus.out_valid  = s4_q.v;
    assign bus.out_diff   = s4_q.diff;
    assign bus.out_borrow = s4_q.borrow;
    assign bus.out_ovf    = s4_q.ovf;
    assign bus.out_zero   = s4_q.zero;
    assign bus.out_tag    = s4_q.tag;
endmodule
